// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input into a circular FIFO, frames
// serialised LSB-first with optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0,
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_bit;
    logic [DIV_W-1:0]     div_cnt;
    logic [3:0]           bit_idx;
    logic                 bit_end;
    logic                 push;
    logic                 pop;

    assign head     = mem[rd_ptr];
    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign busy     = (state != IDLE);
    assign bit_end  = (div_cnt == DIV_W'(DIV - 1));
    assign push     = in_valid && in_ready;
    // A pop either leaves IDLE or chains straight from the last stop cycle into START.
    assign pop      = (fifo_count != '0) &&
                      ((state == IDLE) ||
                       (state == STOP && bit_end && bit_idx == 4'(STOP_BITS - 1)));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            div_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (pop) begin
            shift_reg  <= head;
            parity_bit <= (PARITY_MODE == 2) ? ~^head : ^head;
            state      <= START;
            tx         <= 1'b0;
            div_cnt    <= '0;
            bit_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                end
                START: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= DATA;
                        tx      <= shift_reg[0];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_MODE != 0) begin
                                state <= PARITY;
                                tx    <= parity_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        state   <= STOP;
                        tx      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        if (bit_idx == 4'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four uart_tx_fifo configurations at DIV = 4 (8N1, 8E1, 8O1, 7N2),
// all with a 4-entry FIFO.
module tb_uart_tx_fifo;
    logic       clk;
    logic       reset;
    logic [7:0] d8 [3];
    logic [6:0] d7;
    logic       in_valid [4];
    wire        in_ready_v [4];
    wire        tx_v [4];
    wire        busy_v [4];
    wire  [2:0] cnt_v [4];

    int checks;
    int failures;
    int cur;

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(0), .CLK_FREQ(40),
                   .BAUD_RATE(10), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset(reset), .in_data(d8[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_count(cnt_v[0]));

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(1), .CLK_FREQ(40),
                   .BAUD_RATE(10), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .reset(reset), .in_data(d8[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_count(cnt_v[1]));

    uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_MODE(2), .CLK_FREQ(40),
                   .BAUD_RATE(10), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .reset(reset), .in_data(d8[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_count(cnt_v[2]));

    uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_MODE(0), .CLK_FREQ(40),
                   .BAUD_RATE(10), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .reset(reset), .in_data(d7), .in_valid(in_valid[3]),
        .in_ready(in_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .fifo_count(cnt_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the edge that is offset t from the reference edge.
    task automatic go(input int t);
        repeat (t - cur) @(posedge clk);
        #1;
        cur = t;
    endtask

    // Push one word; check the count after E0 and the frame start after E1.
    task automatic push_one(input int idx, input logic [8:0] data);
        @(negedge clk);
        if (idx == 3) d7 = data[6:0];
        else d8[idx] = data[7:0];
        in_valid[idx] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        chk("count_after_push", 32'(cnt_v[idx]), 32'd1);
        @(posedge clk);
        #1;
        chk("tx_start_edge", 32'(tx_v[idx]), 32'd0);
        chk("busy_start_edge", 32'(busy_v[idx]), 32'd1);
        chk("count_after_pop", 32'(cnt_v[idx]), 32'd0);
    endtask

    // Called 1 ns after E1; samples every bit slot mid-way, then the exact end.
    task automatic watch_frame(input int idx, input logic [15:0] bits, input int nslots);
        for (int s = 0; s < nslots; s++) begin
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("slot%0d_tx", s), 32'(tx_v[idx]), 32'(bits[s]));
            chk($sformatf("slot%0d_busy", s), 32'(busy_v[idx]), 32'd1);
            if (s < nslots - 1) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_last_cycle", 32'(busy_v[idx]), 32'd1);
        @(posedge clk);
        #1;
        chk("busy_after_frame", 32'(busy_v[idx]), 32'd0);
        chk("tx_after_frame", 32'(tx_v[idx]), 32'd1);
    endtask

    initial begin
        logic [7:0] fw [5];
        logic [7:0] rw [4];
        logic [2:0] exp_cnt [5];
        logic [7:0] w;
        int k;

        fw = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h96};
        rw = '{8'h37, 8'h5A, 8'hC3, 8'h81};
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        checks = 0;
        failures = 0;
        cur = 0;
        reset = 1'b0;
        d7 = '0;
        for (int i = 0; i < 3; i++) d8[i] = '0;
        for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;

        // Asynchronous reset mid-cycle: no clock edge between assert and check.
        #17;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx%0d", i), 32'(tx_v[i]), 32'd1);
            chk($sformatf("reset_busy%0d", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("reset_count%0d", i), 32'(cnt_v[i]), 32'd0);
            chk($sformatf("reset_ready%0d", i), 32'(in_ready_v[i]), 32'd1);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1, 0x55: start 0, data 1,0,1,0,1,0,1,0, stop 1.
        push_one(0, 9'h055);
        watch_frame(0, 16'b0000_0010_1010_1010, 10);

        // 8E1, 0x07: parity 1.
        push_one(1, 9'h007);
        watch_frame(1, 16'b0000_0110_0000_1110, 11);

        // 8O1, 0x07: parity 0.
        push_one(2, 9'h007);
        watch_frame(2, 16'b0000_0100_0000_1110, 11);

        // 7N2, 0x7F: start 0, seven 1s, two stop 1s.
        push_one(3, 9'h07F);
        watch_frame(3, 16'b0000_0011_1111_1110, 10);

        // FIFO fill on the depth-4 8N1 unit with in_valid held high.
        @(negedge clk);
        k = 0;
        d8[0] = fw[0];
        in_valid[0] = 1'b1;
        for (int it = 0; it < 10; it++) begin
            if (!in_ready_v[0]) break;
            @(posedge clk);
            #1;
            chk($sformatf("fill_count%0d", k), 32'(cnt_v[0]), 32'(exp_cnt[k < 5 ? k : 4]));
            k++;
            @(negedge clk);
            if (k < 5) d8[0] = fw[k];
        end
        in_valid[0] = 1'b0;
        chk("fill_accepted", 32'(k), 32'd5);
        chk("fill_ready_low", 32'(in_ready_v[0]), 32'd0);

        // Reference edge is the second accepting edge; the next posedge is offset 4.
        cur = 3;
        for (int f = 0; f < 5; f++) begin
            logic [9:0] frame;
            frame = {1'b1, fw[f], 1'b0};
            if (f > 0) begin
                go(40 * f - 1);
                chk($sformatf("b2b%0d_stop_tail", f), 32'(tx_v[0]), 32'd1);
                go(40 * f);
                chk($sformatf("b2b%0d_start_head", f), 32'(tx_v[0]), 32'd0);
                chk($sformatf("b2b%0d_busy", f), 32'(busy_v[0]), 32'd1);
            end
            for (int s = 0; s < 10; s++) begin
                if (f == 0 && s == 0) continue;
                go(40 * f + 4 * s + 2);
                chk($sformatf("b2b%0d_slot%0d", f, s), 32'(tx_v[0]), 32'(frame[s]));
            end
        end
        go(199);
        chk("b2b_busy_last", 32'(busy_v[0]), 32'd1);
        go(200);
        chk("b2b_busy_end", 32'(busy_v[0]), 32'd0);
        chk("b2b_tx_end", 32'(tx_v[0]), 32'd1);
        chk("b2b_count_end", 32'(cnt_v[0]), 32'd0);

        // Reset mid-frame with three words still queued.
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            d8[0] = rw[j];
            in_valid[0] = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid[0] = 1'b0;
        chk("rst_queue_count", 32'(cnt_v[0]), 32'd3);
        cur = 2;
        go(17);
        w = rw[0];
        chk("rst_data_bit3", 32'(tx_v[0]), 32'(w[3]));
        chk("rst_busy_before", 32'(busy_v[0]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(tx_v[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_mid_count", 32'(cnt_v[0]), 32'd0);
        chk("rst_mid_ready", 32'(in_ready_v[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst_tx%0d", c), 32'(tx_v[0]), 32'd1);
            chk($sformatf("post_rst_busy%0d", c), 32'(busy_v[0]), 32'd0);
        end
        chk("post_rst_count", 32'(cnt_v[0]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter for the serial link subsystem. It accepts words over a valid/ready handshake into an internal FIFO and serialises them LSB-first on `tx`. Frame format is set at elaboration time: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. Baud timing comes from an internal integer divider, and queued words go out back-to-back with no idle gap between frames.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame, legal values 1 or 2.
- `PARITY_MODE`, default 0: 0 = none, 1 = even, 2 = odd.
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, ≥2.
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: reset is asynchronous and active-high.
- `in_data` input, `DATA_BITS` bits: word to transmit.
- `in_valid` input, 1 bit: `in_data` is valid this cycle.
- `in_ready` output, 1 bit: the FIFO can accept a word this cycle.
- `tx` output, 1 bit: serial line, idle high.
- `busy` output, 1 bit: a frame is in progress (state ≠ IDLE).
- `fifo_count` output, `$clog2(FIFO_DEPTH+1)` bits: number of words held in the FIFO.

## Operation
- **Divider:** DIV = CLK_FREQ / BAUD_RATE, truncated; DIV ≥ 2 is required.
  - The bit counter restarts at every frame start.
  - Every bit lasts exactly DIV clk cycles.
- **Handshake:** a word is pushed when `in_valid && in_ready`.
  - `in_ready` = (`fifo_count` < FIFO_DEPTH), combinational from the registered count.
  - While full, `in_ready` is 0 even if a pop happens in the same cycle.
  - A push and a pop in the same non-full cycle leave `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `tx` = 1. If the FIFO is non-empty: pop into the shift register, compute parity, go to START.
  - **START:** `tx` = 0 for DIV cycles, then go to DATA.
  - **DATA:** `tx` = shift_reg[0] for DIV cycles, then shift right. After DATA_BITS bits, go to PARITY if PARITY_MODE ≠ 0, else STOP.
  - **PARITY:** `tx` = ^data for even, ~^data for odd; lasts DIV cycles, then go to STOP.
  - **STOP:** `tx` = 1 for STOP_BITS×DIV cycles. At the end:
    - FIFO non-empty: pop and go directly to START (no IDLE cycle).
    - FIFO empty: go to IDLE.
- `tx` is driven from a register, so it is glitch-free.
- The shift register and parity are captured at pop time. Later FIFO activity does not affect the frame in flight.
- **FIFO:** circular buffer with read and write pointers that wrap modulo FIFO_DEPTH; word order is preserved.
- **Reset:** on assertion, independent of clk:
  - outputs go to `tx` = 1, `busy` = 0, `fifo_count` = 0, `in_ready` = 1;
  - state = IDLE, pointers = 0, divider = 0.
- Reset mid-frame aborts the frame and flushes the FIFO. Nothing is retransmitted after release.
- Illegal parameter values are rejected at elaboration.

## Timing
- Frame length = (1 + DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS) × DIV cycles.
- **First-word latency:** word accepted on edge E0 while IDLE with the FIFO empty.
  - `fifo_count` = 1 after E0.
  - Pop and START on E1, so `tx` falls and `busy` rises after E1.
- **Back-to-back frames:** the first START cycle immediately follows the last STOP cycle. `busy` stays 1 throughout.
- `busy` falls on the edge that ends the last stop bit when the FIFO is empty.
- `fifo_count` decrements on the pop edge (E1 above) and increments on the push edge.

## Test plan
- **Reset values:** assert `reset` asynchronously mid-cycle → `tx` = 1, `busy` = 0, `fifo_count` = 0, `in_ready` = 1 immediately.
- **Single frame, 8N1, DIV = 4 (CLK_FREQ = 4×BAUD_RATE):** push 0x55 → after E1 `tx` is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. `busy` is high for exactly 40 cycles.
- **Parity, 8 data bits, DIV = 4:** push 0x07.
  - Even parity: 1 in bit slot 9; frame length 44 cycles.
  - Odd parity: 0 in bit slot 9.
- **FIFO fill, FIFO_DEPTH = 4:** hold `in_valid` = 1 from idle.
  - Exactly 5 words are accepted before `in_ready` drops, with `fifo_count` sequence 1,1,2,3,4.
  - Five frames go out back-to-back in push order with no high gap beyond stop bits.
- **7 data bits, 2 stop bits, no parity, DIV = 4:** push 0x7F → frame of 40 cycles with `tx` high for the last 8 cycles.
- **Reset mid-frame:** FIFO holds 3 words; assert `reset` during data bit 3 → `tx` = 1 and `busy` = 0 at once, `fifo_count` = 0. After release, `tx` stays 1 with no `in_valid`.
